atmega_pcint: RTL and testbench

ATMEGA_PCINT -- requirements
Module: atmega_pcint

---
 rtl/atmega_pcint.sv | 239 +++++++++++++++++++++++
 tb/tb_atmega_pcint.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_pcint.sv
// atmega_pcint: pin-change interrupt block.
//
// Each io_in pin is synchronized (sync1 -> sync2), compared against a "prev" copy of
// itself, and a qualified rising/falling edge sets a sticky per-pin flag in PCIFR.
// irq is PCIE (PCICR[0]) AND any pending flag. Flags are write-one-to-clear, and
// int_ack clears all of them. A newly detected edge always beats a clear that lands
// on the same bit in the same cycle.
//
// After reset a small prime counter holds off edge detection until the pipeline has
// filled, so pins that are already high at reset do not report a rise.
//
// Optional build macro:
//   ATMEGA_PCINT_FILTER_EN - inserts a per-pin glitch filter between sync2 and prev.
//                            The level only moves after 3 consecutive identical sync2
//                            samples, adding 2 cycles of latency; priming stretches
//                            to cover the filter depth.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   addr     register address
//   wr       write strobe
//   rd       read strobe
//   bus_in   write data
//   bus_out  read data (combinational, 0 when not reading)
//   io_in    asynchronous pin levels
//   int_ack  interrupt acknowledge, clears all flags
//   irq      interrupt request
module atmega_pcint #(
  parameter int unsigned                 BUS_ADDR_DATA_LEN = 8,
  parameter int unsigned                 PORT_WIDTH        = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR        = 'h00,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCICR_ADDR        = 'h01,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIFR_ADDR        = 'h02,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] RISE_ADDR         = 'h03,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] FALL_ADDR         = 'h04,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PINSYNC_ADDR      = 'h05
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [PORT_WIDTH-1:0]        bus_in,
  output logic [PORT_WIDTH-1:0]        bus_out,
  input  logic [PORT_WIDTH-1:0]        io_in,
  input  logic                         int_ack,
  output logic                         irq
);

  // Prime counter: detection is enabled once it saturates.
`ifdef ATMEGA_PCINT_FILTER_EN
  localparam int unsigned      PrimeW   = 3;
  localparam logic [PrimeW-1:0] PrimeMax = 3'd5;
`else
  localparam int unsigned      PrimeW   = 2;
  localparam logic [PrimeW-1:0] PrimeMax = 2'd3;
`endif

  logic [PrimeW-1:0]     prime_q, prime_d;
  logic                  det_en;

  logic [PORT_WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [PORT_WIDTH-1:0] lvl;

  logic [PORT_WIDTH-1:0] pcmsk_q, pcmsk_d;
  logic                  pcie_q, pcie_d;
  logic [PORT_WIDTH-1:0] pcifr_q, pcifr_d;
  logic [PORT_WIDTH-1:0] rise_q, rise_d;
  logic [PORT_WIDTH-1:0] fall_q, fall_d;

  logic [PORT_WIDTH-1:0] rise_det, fall_det;
  logic [PORT_WIDTH-1:0] set_vec, clr_vec;

  logic                  wr_pcmsk, wr_pcicr, wr_pcifr, wr_rise, wr_fall;

  assign wr_pcmsk = wr && (addr == PCMSK_ADDR);
  assign wr_pcicr = wr && (addr == PCICR_ADDR);
  assign wr_pcifr = wr && (addr == PCIFR_ADDR);
  assign wr_rise  = wr && (addr == RISE_ADDR);
  assign wr_fall  = wr && (addr == FALL_ADDR);

  // ---------------------------------------------------------------------------
  // Synchronizer and prev tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef ATMEGA_PCINT_FILTER_EN
  // Glitch filter: hist holds the two previous sync2 samples. When the current sample
  // agrees with both, the filtered level follows it in the same cycle; otherwise it
  // holds. This gives exactly 2 extra cycles over the unfiltered path.
  logic [PORT_WIDTH-1:0] hist0_q, hist1_q, filt_q;
  logic [PORT_WIDTH-1:0] agree, filt_lvl;

  always_comb begin
    agree    = ~(sync2_q ^ hist0_q) & ~(sync2_q ^ hist1_q);
    filt_lvl = (agree & sync2_q) | (~agree & filt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist0_q <= '0;
      hist1_q <= '0;
      filt_q  <= '0;
    end else begin
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
      filt_q  <= filt_lvl;
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sync2_q;
`endif

  // prev keeps tracking during priming so a pin already high settles without an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= lvl;
    end
  end

  // ---------------------------------------------------------------------------
  // Prime counter
  // ---------------------------------------------------------------------------
  always_comb begin
    prime_d = prime_q;
    if (prime_q != PrimeMax) begin
      prime_d = prime_q + PrimeW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prime_q <= '0;
    end else begin
      prime_q <= prime_d;
    end
  end

  assign det_en = (prime_q == PrimeMax);

  // ---------------------------------------------------------------------------
  // Edge detection and flag next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    rise_det = lvl & ~prev_q;
    fall_det = ~lvl & prev_q;
    set_vec  = '0;
    if (det_en) begin
      set_vec = pcmsk_q & ((rise_det & rise_q) | (fall_det & fall_q));
    end

    clr_vec = '0;
    if (int_ack) begin
      clr_vec = '1;
    end
    if (wr_pcifr) begin
      clr_vec = clr_vec | bus_in;
    end

    // Set is OR'd in after the clear so a same-cycle edge wins.
    pcifr_d = (pcifr_q & ~clr_vec) | set_vec;
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_comb begin
    pcmsk_d = pcmsk_q;
    pcie_d  = pcie_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    if (wr_pcmsk) begin
      pcmsk_d = bus_in;
    end
    if (wr_pcicr) begin
      pcie_d = bus_in[0];
    end
    if (wr_rise) begin
      rise_d = bus_in;
    end
    if (wr_fall) begin
      fall_d = bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcmsk_q <= '0;
      pcie_q  <= 1'b0;
      pcifr_q <= '0;
      rise_q  <= '1;
      fall_q  <= '1;
    end else begin
      pcmsk_q <= pcmsk_d;
      pcie_q  <= pcie_d;
      pcifr_q <= pcifr_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign irq = pcie_q & (|pcifr_q);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_out = '0;
    if (rd && !rst) begin
      if (addr == PCMSK_ADDR) begin
        bus_out = pcmsk_q;
      end else if (addr == PCICR_ADDR) begin
        bus_out = {{(PORT_WIDTH-1){1'b0}}, pcie_q};
      end else if (addr == PCIFR_ADDR) begin
        bus_out = pcifr_q;
      end else if (addr == RISE_ADDR) begin
        bus_out = rise_q;
      end else if (addr == FALL_ADDR) begin
        bus_out = fall_q;
      end else if (addr == PINSYNC_ADDR) begin
        bus_out = lvl;
      end
    end
  end

endmodule

// File: tb/tb_atmega_pcint.sv
// Self-checking bench for atmega_pcint: a register access table, directed multi-cycle
// sequences with constant expectations, then randomized traffic against a model built
// from the raw io_in history.
module tb_atmega_pcint;

`ifdef ATMEGA_PCINT_FILTER_EN
  localparam int Lat      = 4;
  localparam bit FiltOn   = 1'b1;
  localparam int PrimeMax = 5;
`else
  localparam int Lat      = 2;
  localparam bit FiltOn   = 1'b0;
  localparam int PrimeMax = 3;
`endif

  localparam logic [7:0] AMsk  = 8'h00;
  localparam logic [7:0] ACr   = 8'h01;
  localparam logic [7:0] AIfr  = 8'h02;
  localparam logic [7:0] ARise = 8'h03;
  localparam logic [7:0] AFall = 8'h04;
  localparam logic [7:0] ASync = 8'h05;

  logic       clk = 1'b0;
  logic       rst, wr, rd, int_ack;
  logic [7:0] addr, bus_in, io_in;
  logic [7:0] bus_out;
  logic       irq;

  int checks = 0;
  int errors = 0;

  atmega_pcint dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr      (wr),
    .rd      (rd),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .io_in   (io_in),
    .int_ack (int_ack),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: stores io_in as sampled at every edge since reset and derives
  // the observed pin level from that history.
  // ---------------------------------------------------------------------------
  logic [7:0] hs [0:8191];
  logic [7:0] fl [0:8191];
  int         mn;
  logic [7:0] m_msk, m_rise, m_fall, m_ifr;
  logic       m_ie;

  function automatic logic [7:0] s_at(input int m);
    return (m <= 0) ? 8'h00 : hs[m];
  endfunction

  function automatic logic [7:0] f_at(input int m);
    return (m <= 0) ? 8'h00 : fl[m];
  endfunction

  // Filtered level seen before edge m: follows raw level only if 3 samples agree.
  function automatic logic [7:0] fcalc(input int m);
    logic [7:0] a, b, c, p, r;
    a = s_at(m - 2);
    b = s_at(m - 3);
    c = s_at(m - 4);
    p = f_at(m - 1);
    for (int i = 0; i < 8; i++) begin
      if (a[i] == b[i] && a[i] == c[i]) r[i] = a[i];
      else r[i] = p[i];
    end
    return r;
  endfunction

  // Level seen by the edge detector just before edge m.
  function automatic logic [7:0] lvl_at(input int m);
    if (FiltOn) return (m <= 0) ? 8'h00 : f_at(m);
    return s_at(m - 2);
  endfunction

  function automatic logic [7:0] pin_now();
    if (FiltOn) return fcalc(mn + 1);
    return s_at(mn - 1);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      AMsk:    return m_msk;
      ACr:     return {7'b0, m_ie};
      AIfr:    return m_ifr;
      ARise:   return m_rise;
      AFall:   return m_fall;
      ASync:   return pin_now();
      default: return 8'h00;
    endcase
  endfunction

  task automatic mdl_edge();
    logic [7:0] cur, old, setv, clrv;
    if (rst) begin
      mn     = 0;
      m_msk  = 8'h00;
      m_rise = 8'hFF;
      m_fall = 8'hFF;
      m_ifr  = 8'h00;
      m_ie   = 1'b0;
    end else begin
      mn++;
      hs[mn] = io_in;
      fl[mn] = fcalc(mn);
      setv   = 8'h00;
      if (mn >= PrimeMax + 1) begin
        cur = lvl_at(mn);
        old = lvl_at(mn - 1);
        for (int i = 0; i < 8; i++) begin
          if (m_msk[i] && cur[i] && !old[i] && m_rise[i]) setv[i] = 1'b1;
          if (m_msk[i] && !cur[i] && old[i] && m_fall[i]) setv[i] = 1'b1;
        end
      end
      clrv = int_ack ? 8'hFF : 8'h00;
      if (wr && addr == AIfr) clrv = clrv | bus_in;
      m_ifr = (m_ifr & ~clrv) | setv;
      if (wr) begin
        case (addr)
          AMsk:    m_msk = bus_in;
          ACr:     m_ie = bus_in[0];
          ARise:   m_rise = bus_in;
          AFall:   m_fall = bus_in;
          default: ;
        endcase
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Helpers: inputs change at negedge; one cyc() crosses one rising edge.
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
    wr   = 1'b0;
    rd   = 1'b1;
    addr = a;
    #1;
    chk(name, bus_out, exp);
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    addr   = a;
    bus_in = d;
    wr     = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    wr      = 1'b0;
    rd      = 1'b0;
    int_ack = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Edge already applied to io_in before the next edge k; expects flags exactly at k+Lat.
  task automatic flag_wait(input logic [7:0] exp, input string name);
    for (int j = 0; j <= Lat; j++) begin
      cyc();
      rd_chk(AIfr, (j == Lat) ? exp : 8'h00, name);
    end
  endtask

  // Pulse of w cycles on io_in[2]; flag expected from offset 'at' (or never if at < 0).
  task automatic pulse(input int w, input int at, input string name);
    int last;
    last = (at >= 0) ? at : 10;
    io_in[2] = 1'b1;
    for (int j = 0; j <= last; j++) begin
      cyc();
      if (j == w - 1) io_in[2] = 1'b0;
      rd_chk(AIfr, (at >= 0 && j >= at) ? 8'h04 : 8'h00, name);
    end
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [19];

  initial begin
    logic [7:0] flip;
    logic [7:0] exp_bus;
    int         op;

    vt[0]  = '{1'b0, 1'b1, AMsk,  8'h00, 8'h00};
    vt[1]  = '{1'b0, 1'b1, ACr,   8'h00, 8'h00};
    vt[2]  = '{1'b0, 1'b1, AIfr,  8'h00, 8'h00};
    vt[3]  = '{1'b0, 1'b1, ARise, 8'h00, 8'hFF};
    vt[4]  = '{1'b0, 1'b1, AFall, 8'h00, 8'hFF};
    vt[5]  = '{1'b0, 1'b1, ASync, 8'h00, 8'h00};
    vt[6]  = '{1'b1, 1'b0, AMsk,  8'hA5, 8'h00};
    vt[7]  = '{1'b0, 1'b1, AMsk,  8'h00, 8'hA5};
    vt[8]  = '{1'b1, 1'b0, ACr,   8'hFF, 8'h00};
    vt[9]  = '{1'b0, 1'b1, ACr,   8'h00, 8'h01};
    vt[10] = '{1'b1, 1'b0, ARise, 8'h3C, 8'h00};
    vt[11] = '{1'b0, 1'b1, ARise, 8'h00, 8'h3C};
    vt[12] = '{1'b1, 1'b0, AFall, 8'hC3, 8'h00};
    vt[13] = '{1'b0, 1'b1, AFall, 8'h00, 8'hC3};
    vt[14] = '{1'b1, 1'b0, ASync, 8'h55, 8'h00};
    vt[15] = '{1'b0, 1'b1, ASync, 8'h00, 8'h00};
    vt[16] = '{1'b1, 1'b0, 8'h09, 8'h77, 8'h00};
    vt[17] = '{1'b0, 1'b1, 8'h09, 8'h00, 8'h00};
    vt[18] = '{1'b0, 1'b0, AMsk,  8'h00, 8'h00};

    rst = 1'b1; wr = 1'b0; rd = 1'b0; int_ack = 1'b0;
    addr = 8'h00; bus_in = 8'h00; io_in = 8'h00;
    @(negedge clk);

    // Register table
    reset_dut();
    for (int i = 0; i < 19; i++) begin
      wr = vt[i].wr; rd = vt[i].rd; addr = vt[i].addr; bus_in = vt[i].din;
      #1;
      chk($sformatf("vec%0d", i), bus_out, vt[i].exp);
      cyc();
      wr = 1'b0; rd = 1'b0;
    end
    chk("vec_irq", irq, 1'b0);

    // Pins high through reset never flag
    io_in = 8'hFF;
    reset_dut();
    wr_reg(AMsk, 8'hFF);
    wr_reg(ACr, 8'h01);
    for (int j = 0; j < 10; j++) begin
      rd_chk(AIfr, 8'h00, "hi_at_reset");
      cyc();
    end
    chk("hi_at_reset_irq", irq, 1'b0);
    rd_chk(ASync, 8'hFF, "pinsync_ff");
    io_in = 8'h00;

    // Basic rise on pin 0, exact latency, then W1C
    reset_dut();
    wr_reg(AMsk, 8'h01);
    wr_reg(ACr, 8'h01);
    repeat (6) cyc();
    io_in[0] = 1'b1;
    flag_wait(8'h01, "rise0");
    chk("rise0_irq", irq, 1'b1);
    wr_reg(AIfr, 8'h01);
    rd_chk(AIfr, 8'h00, "w1c0");
    chk("w1c0_irq", irq, 1'b0);
    io_in = 8'h00;

    // Fall-only enable on pin 1
    reset_dut();
    wr_reg(ARise, 8'h00);
    wr_reg(AFall, 8'h02);
    wr_reg(AMsk, 8'h02);
    repeat (6) cyc();
    io_in[1] = 1'b1;
    repeat (Lat + 3) cyc();
    rd_chk(AIfr, 8'h00, "rise1_off");
    io_in[1] = 1'b0;
    flag_wait(8'h02, "fall1");

    // Edge on pin 3 in the same cycle as int_ack
    reset_dut();
    wr_reg(AMsk, 8'hFF);
    wr_reg(ACr, 8'h01);
    repeat (6) cyc();
    io_in[0] = 1'b1;
    flag_wait(8'h01, "pre_ack");
    io_in[3] = 1'b1;
    repeat (Lat) cyc();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    rd_chk(AIfr, 8'h08, "ack_set_wins");
    chk("ack_irq", irq, 1'b1);
    io_in = 8'h00;

    // PCIE masking, flag retention, mid-operation reset
    reset_dut();
    wr_reg(AMsk, 8'hFF);
    repeat (6) cyc();
    io_in[4] = 1'b1;
    flag_wait(8'h10, "pend4");
    chk("pend4_irq_off", irq, 1'b0);
    wr_reg(ACr, 8'h01);
    chk("pcie_on_irq", irq, 1'b1);
    wr_reg(AMsk, 8'h00);
    rd_chk(AIfr, 8'h10, "msk_keeps_flag");
    wr_reg(ACr, 8'h00);
    chk("pcie_off_irq", irq, 1'b0);
    rd_chk(AIfr, 8'h10, "pcie_keeps_flag");
    rst = 1'b1;
    rd_chk(AIfr, 8'h00, "rd_in_rst");
    cyc();
    rst = 1'b0;
    rd_chk(AIfr, 8'h00, "rst_clears");
    rd_chk(ARise, 8'hFF, "rst_rise");
    wr_reg(AMsk, 8'hFF);
    repeat (10) cyc();
    rd_chk(AIfr, 8'h00, "reprime");
    io_in = 8'h00;

    // Short pulses on pin 2
    reset_dut();
    wr_reg(AMsk, 8'h04);
    repeat (8) cyc();
`ifdef ATMEGA_PCINT_FILTER_EN
    pulse(2, -1, "glitch2");
    pulse(3, 4, "pulse3");
`else
    pulse(1, 2, "pulse1");
`endif
    io_in = 8'h00;

    // Randomized traffic against the model
    reset_dut();
    for (int c = 0; c < 2500; c++) begin
      flip = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) flip[i] = 1'b1;
      end
      io_in  = io_in ^ flip;
      wr     = 1'b0;
      rd     = 1'b0;
      addr   = 8'h00;
      bus_in = 8'($urandom);
      op     = int'($urandom_range(0, 15));
      case (op)
        0:       begin wr = 1'b1; addr = AMsk; end
        1:       begin wr = 1'b1; addr = ARise; end
        2:       begin wr = 1'b1; addr = AFall; end
        3:       begin wr = 1'b1; addr = ACr; end
        4:       begin wr = 1'b1; addr = AIfr; end
        5:       begin wr = 1'b1; addr = ASync; end
        6:       begin wr = 1'b1; addr = 8'($urandom_range(6, 255)); end
        7:       begin rd = 1'b1; addr = ASync; end
        8:       begin rd = 1'b1; addr = ACr; end
        9:       begin rd = 1'b1; addr = AMsk; end
        default: begin rd = 1'b1; addr = AIfr; end
      endcase
      int_ack = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      #1;
      exp_bus = (rst || !rd) ? 8'h00 : m_read(addr);
      chk("rand_bus", bus_out, exp_bus);
      chk("rand_irq", irq, m_ie & (|m_ifr));
      @(posedge clk);
      mdl_edge();
      @(negedge clk);
    end
    rst = 1'b0; wr = 1'b0; rd = 1'b0; int_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
